// File: rtl/btn_debouncer_multi.sv
// Multi-channel button conditioner: synchroniser, stable-sample filter,
// registered edge pulses and optional hold-to-auto-repeat per channel.
// Ports:
//   clk      system clock, all logic on posedge
//   rst      synchronous reset, active-low
//   en       filter enable; 0 freezes counters and level, gates pulses
//   in_n     raw asynchronous button inputs, 1 = pressed
//   level_o  debounced level
//   rise_o   1-cycle pulse on debounced 0->1
//   fall_o   1-cycle pulse on debounced 1->0
//   event_o  selected edge pulse(s) OR auto-repeat pulse
module btn_debouncer_multi #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int EDGE_MODE     = 0,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CHANNELS-1:0] in_n,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic [CHANNELS-1:0] event_o
);

    localparam int CW   = $clog2(STABLE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] C_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PER  = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] R_ONE  = RW'(1);
    localparam logic          RPT_EN = (REPEAT_DELAY > 0);

    localparam logic [CHANNELS-1:0] RISE_MASK =
        (EDGE_MODE != 1) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};
    localparam logic [CHANNELS-1:0] FALL_MASK =
        (EDGE_MODE != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

    logic [SYNC_STAGES-1:0] sync [CHANNELS];
    logic [CW-1:0]          cnt  [CHANNELS];
    logic [RW-1:0]          rpt  [CHANNELS];
    logic [RW-1:0]          rpt_inc [CHANNELS];
    // Set once the first repeat has fired; switches the terminal
    // count from the initial delay to the repeat period.
    logic [CHANNELS-1:0]    rpt_armed;

    logic [CHANNELS-1:0] sync_out;
    logic [CHANNELS-1:0] differ;
    logic [CHANNELS-1:0] flip;
    logic [CHANNELS-1:0] rise_n;
    logic [CHANNELS-1:0] fall_n;
    logic [CHANNELS-1:0] rpt_hit;

    always_comb begin
        sync_out = '0;
        differ   = '0;
        flip     = '0;
        rise_n   = '0;
        fall_n   = '0;
        rpt_hit  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rpt_inc[i]  = rpt[i] + R_ONE;
            sync_out[i] = sync[i][SYNC_STAGES-1];
            differ[i]   = sync_out[i] != level_o[i];
            flip[i]     = en && differ[i] && (cnt[i] == C_LAST);
            rise_n[i]   = flip[i] && sync_out[i];
            fall_n[i]   = flip[i] && !sync_out[i];
            // A level change takes priority: no repeat on the fall cycle.
            rpt_hit[i]  = RPT_EN && en && level_o[i] && !flip[i] &&
                          (rpt_armed[i] ? (rpt_inc[i] == R_PER)
                                        : (rpt_inc[i] == R_DLY));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync[i] <= '0;
                cnt[i]  <= '0;
                rpt[i]  <= '0;
            end
            rpt_armed <= '0;
            level_o   <= '0;
            rise_o    <= '0;
            fall_o    <= '0;
            event_o   <= '0;
        end else begin
            rise_o  <= rise_n;
            fall_o  <= fall_n;
            event_o <= (rise_n & RISE_MASK) | (fall_n & FALL_MASK) | rpt_hit;
            for (int i = 0; i < CHANNELS; i++) begin
                // Synchroniser keeps running even when filtering is frozen.
                sync[i] <= {sync[i][SYNC_STAGES-2:0], in_n[i]};
                if (en) begin
                    if (flip[i]) begin
                        level_o[i]   <= sync_out[i];
                        cnt[i]       <= '0;
                        rpt[i]       <= '0;
                        rpt_armed[i] <= 1'b0;
                    end else begin
                        if (differ[i]) begin
                            cnt[i] <= cnt[i] + C_ONE;
                        end else begin
                            cnt[i] <= '0;
                        end
                        if (RPT_EN && level_o[i]) begin
                            if (rpt_hit[i]) begin
                                rpt[i]       <= '0;
                                rpt_armed[i] <= 1'b1;
                            end else begin
                                rpt[i] <= rpt_inc[i];
                            end
                        end
                    end
                end
            end
        end
    end

endmodule
